// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC / fetch slice: word width, NOP encoding,
// fetch FSM states and the buffered instruction entry.
package npc_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_DISCARD,
      ST_HALT
   } fetch_state_t;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer; slot0 is always the head so the outputs come
// straight from a register.
module fetch_fifo
   import npc_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_DATA = NOP_INST
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam fetch_entry_t RESET_ENTRY = '{err: 1'b0, pc: '0, data: RESET_DATA};

   logic [1:0]   count;
   fetch_entry_t slot0;
   fetch_entry_t slot1;
   logic         do_push;
   logic         do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign head    = slot0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // A push and pop on the same edge both land: the new entry slides in behind
   // whatever becomes the new head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         slot0 <= RESET_ENTRY;
         slot1 <= RESET_ENTRY;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) begin
                  slot0 <= push_data;
               end else begin
                  slot1 <= push_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: one outstanding memory request, a two-entry
// instruction buffer, redirect handling and halt-on-fault.
module inst_fetch
   import npc_pkg::*;
#(
   parameter logic [XLEN-1:0] START_ADDR = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST   = npc_pkg::NOP_INST
) (
   input  logic            clk,
   input  logic            global_rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_req_ready,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_data,
   input  logic            mem_resp_err,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err,
   input  logic            inst_ready
);

   fetch_state_t    state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] inflight_pc;
   logic            misalign_pend;
   logic            handshake;
   logic            in_flight;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   // Reset gates the request so nothing is offered while global_rst is low,
   // and the first request is accepted on the first edge after release.
   assign mem_req_valid = global_rst && (state == ST_REQ) && !misalign_pend &&
                          !fifo_full && !redirect_valid;
   assign mem_req_addr  = fetch_pc;
   assign handshake     = mem_req_valid && mem_req_ready;
   assign in_flight     = (((state == ST_WAIT) || (state == ST_DISCARD)) && !mem_resp_valid) ||
                          handshake;

   assign inst_valid = !fifo_empty;
   assign inst       = head.data;
   assign inst_pc    = head.pc;
   assign inst_err   = head.err;
   assign pop        = inst_valid && inst_ready;

   always_comb begin
      push       = 1'b0;
      push_entry = '{err: 1'b0, pc: inflight_pc, data: mem_resp_data};
      if (!redirect_valid) begin
         if ((state == ST_WAIT) && mem_resp_valid) begin
            push       = 1'b1;
            push_entry = '{err: mem_resp_err, pc: inflight_pc,
                           data: mem_resp_err ? NOP_INST : mem_resp_data};
         end else if ((state == ST_REQ) && misalign_pend) begin
            push       = 1'b1;
            push_entry = '{err: 1'b1, pc: fetch_pc, data: NOP_INST};
         end
      end
   end

   // Redirect wins over everything; a misaligned target is parked until any
   // in-flight response has been swallowed, then turned into a fault entry.
   always_ff @(posedge clk or negedge global_rst) begin
      if (!global_rst) begin
         state         <= ST_REQ;
         fetch_pc      <= START_ADDR;
         inflight_pc   <= '0;
         misalign_pend <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc      <= redirect_pc;
         misalign_pend <= (redirect_pc[1:0] != 2'b00);
         state         <= in_flight ? ST_DISCARD : ST_REQ;
      end else begin
         case (state)
            ST_REQ: begin
               if (misalign_pend) begin
                  misalign_pend <= 1'b0;
                  state         <= ST_HALT;
               end else if (handshake) begin
                  inflight_pc <= fetch_pc;
                  fetch_pc    <= fetch_pc + 32'd4;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_resp_valid) begin
                  state <= mem_resp_err ? ST_HALT : ST_REQ;
               end
            end
            ST_DISCARD: begin
               if (mem_resp_valid) begin
                  state <= ST_REQ;
               end
            end
            default: begin
            end
         endcase
      end
   end

   fetch_fifo #(
      .RESET_DATA(NOP_INST)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (global_rst),
      .flush    (redirect_valid),
      .push     (push),
      .push_data(push_entry),
      .pop      (pop),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scenario bench for inst_fetch with a small bench-side memory that
// answers each accepted request after one or two cycles.
module tb_inst_fetch;

   logic        clk;
   logic        global_rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;
   logic        inst_ready;

   int          checks;
   int          errors;
   int          hs_count;
   logic [31:0] last_hs_addr;
   logic        auto_mem;
   logic        lat2;
   logic [31:0] err_addr;
   logic        p1_v, p2_v;
   logic [31:0] p1_a, p2_a;
   logic [31:0] pop_pc[$];
   logic [31:0] pop_inst[$];
   logic        pop_err[$];

   inst_fetch dut (
      .clk           (clk),
      .global_rst    (global_rst),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .mem_resp_err  (mem_resp_err),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .inst_err      (inst_err),
      .inst_ready    (inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: mem_word = 32'h0010_0093;
         32'h0000_0004: mem_word = 32'h0020_0113;
         32'h0000_0008: mem_word = 32'h0030_0193;
         default:       mem_word = 32'hA000_0000 | addr;
      endcase
   endfunction

   // One clock: sample handshake/pop before the edge, then play the memory.
   task automatic cycle();
      logic        hs;
      logic [31:0] hs_addr;
      logic        rv;
      logic [31:0] ra;
      #1;
      hs      = mem_req_valid && mem_req_ready;
      hs_addr = mem_req_addr;
      if (inst_valid && inst_ready) begin
         pop_pc.push_back(inst_pc);
         pop_inst.push_back(inst);
         pop_err.push_back(inst_err);
      end
      @(posedge clk);
      #1;
      if (hs) begin
         hs_count++;
         last_hs_addr = hs_addr;
      end
      if (auto_mem) begin
         p2_v = p1_v;
         p2_a = p1_a;
         p1_v = hs;
         p1_a = hs_addr;
         rv   = lat2 ? p2_v : p1_v;
         ra   = lat2 ? p2_a : p1_a;
         mem_resp_valid = rv;
         mem_resp_data  = rv ? mem_word(ra) : 32'h0;
         mem_resp_err   = rv && (ra == err_addr);
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_until_hs(input int target, input int budget, output bit ok);
      int n;
      n = 0;
      while (hs_count < target && n < budget) begin
         cycle();
         n++;
      end
      ok = (hs_count >= target);
   endtask

   task automatic run_until_pops(input int target, input int budget, output bit ok);
      int n;
      n = 0;
      while (pop_pc.size() < target && n < budget) begin
         cycle();
         n++;
      end
      ok = (pop_pc.size() >= target);
   endtask

   task automatic clear_pops();
      pop_pc.delete();
      pop_inst.delete();
      pop_err.delete();
   endtask

   task automatic do_reset(input logic rdy, input logic irdy, input logic use_lat2);
      global_rst     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      mem_resp_err   = 1'b0;
      inst_ready     = 1'b0;
      auto_mem       = 1'b1;
      lat2           = use_lat2;
      err_addr       = 32'hFFFF_FFFF;
      p1_v = 1'b0; p2_v = 1'b0; p1_a = 32'h0; p2_a = 32'h0;
      hs_count       = 0;
      last_hs_addr   = 32'hDEAD_DEAD;
      clear_pops();
      @(posedge clk);
      @(posedge clk);
      #2;
      mem_req_ready = rdy;
      inst_ready    = irdy;
      global_rst    = 1'b1;
   endtask

   task automatic test_reset();
      global_rst     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      mem_resp_err   = 1'b0;
      inst_ready     = 1'b1;
      auto_mem       = 1'b1;
      lat2           = 1'b0;
      err_addr       = 32'hFFFF_FFFF;
      p1_v = 1'b0; p2_v = 1'b0; p1_a = 32'h0; p2_a = 32'h0;
      hs_count       = 0;
      clear_pops();
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", inst_valid); end
      checks++; if (inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 00000013", inst); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
      checks++; if (inst_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_err: got %b expected 0", inst_err); end
      global_rst = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL release_req_valid: got %b expected 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL release_req_addr: got %h expected 00000000", mem_req_addr); end
      cycle();
      checks++; if (hs_count !== 1 || last_hs_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_handshake: got count %0d addr %h expected 1 / 00000000", hs_count, last_hs_addr); end
   endtask

   task automatic test_basic_fetch();
      bit ok;
      do_reset(1'b1, 1'b1, 1'b0);
      run_until_pops(2, 20, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout: got %0d pops expected 2", pop_pc.size()); end
      checks++; if (pop_pc[0] !== 32'h0 || pop_inst[0] !== 32'h0010_0093 || pop_err[0] !== 1'b0) begin errors++; $display("[TB] FAIL basic_first: got pc %h inst %h err %b expected 00000000 00100093 0", pop_pc[0], pop_inst[0], pop_err[0]); end
      checks++; if (pop_pc[1] !== 32'h4 || pop_inst[1] !== 32'h0020_0113 || pop_err[1] !== 1'b0) begin errors++; $display("[TB] FAIL basic_second: got pc %h inst %h err %b expected 00000004 00200113 0", pop_pc[1], pop_inst[1], pop_err[1]); end
   endtask

   task automatic test_stall();
      bit ok;
      do_reset(1'b1, 1'b0, 1'b0);
      run_cycles(10);
      checks++; if (hs_count !== 2) begin errors++; $display("[TB] FAIL stall_requests: got %0d expected 2", hs_count); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_valid: got %b expected 0", mem_req_valid); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0010_0093) begin errors++; $display("[TB] FAIL stall_head: got v %b pc %h inst %h expected 1 00000000 00100093", inst_valid, inst_pc, inst); end
      inst_ready = 1'b1;
      run_until_pops(3, 20, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_drain_timeout: got %0d pops expected 3", pop_pc.size()); end
      checks++; if (pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) begin errors++; $display("[TB] FAIL stall_order: got %h %h %h expected 00000000 00000004 00000008", pop_pc[0], pop_pc[1], pop_pc[2]); end
      checks++; if (pop_inst[2] !== 32'h0030_0193) begin errors++; $display("[TB] FAIL stall_third_inst: got %h expected 00300193", pop_inst[2]); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset(1'b1, 1'b0, 1'b0);
      run_until_hs(2, 20, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d requests expected 2", hs_count); end
      inst_ready = 1'b1;
      cycle();
      inst_ready = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'h0020_0113) begin errors++; $display("[TB] FAIL b2b_push_pop: got v %b pc %h inst %h expected 1 00000004 00200113", inst_valid, inst_pc, inst); end
      checks++; if (pop_pc.size() !== 1) begin errors++; $display("[TB] FAIL b2b_pop_count: got %0d expected 1", pop_pc.size()); end
   endtask

   task automatic test_redirect_wait();
      bit ok;
      do_reset(1'b1, 1'b1, 1'b1);
      run_until_hs(3, 30, ok);
      checks++; if (!ok || last_hs_addr !== 32'h8) begin errors++; $display("[TB] FAIL redir_setup: got addr %h expected 00000008", last_hs_addr); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      clear_pops();
      cycle();
      redirect_valid = 1'b0;
      cycle();
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop: got inst_valid %b pc %h expected 0", inst_valid, inst_pc); end
      run_until_hs(4, 10, ok);
      checks++; if (!ok || last_hs_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 00000100", last_hs_addr); end
      run_until_pops(1, 10, ok);
      checks++; if (!ok || pop_pc[0] !== 32'h100 || pop_inst[0] !== 32'hA000_0100) begin errors++; $display("[TB] FAIL redir_first_inst: got pc %h inst %h expected 00000100 a0000100", pop_pc[0], pop_inst[0]); end
   endtask

   task automatic test_redirect_same_cycle();
      bit ok;
      do_reset(1'b1, 1'b1, 1'b0);
      run_until_hs(3, 20, ok);
      checks++; if (!ok || last_hs_addr !== 32'h8) begin errors++; $display("[TB] FAIL redir_same_setup: got addr %h expected 00000008", last_hs_addr); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      cycle();
      redirect_valid = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_same_req: got v %b addr %h expected 1 00000100", mem_req_valid, mem_req_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_same_drop: got inst_valid %b expected 0", inst_valid); end
   endtask

   task automatic test_misaligned();
      bit ok;
      do_reset(1'b1, 1'b0, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_redirect_blocks: got %b expected 0", mem_req_valid); end
      cycle();
      redirect_valid = 1'b0;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_no_request: got %b expected 0", mem_req_valid); end
      cycle();
      checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 32'h102 || inst_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_entry: got v %b inst %h pc %h err %b expected 1 00000013 00000102 1", inst_valid, inst, inst_pc, inst_err); end
      inst_ready = 1'b1;
      run_cycles(8);
      checks++; if (hs_count !== 0 || inst_valid !== 1'b0 || pop_pc.size() !== 1) begin errors++; $display("[TB] FAIL mis_halt: got reqs %0d valid %b pops %0d expected 0 0 1", hs_count, inst_valid, pop_pc.size()); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      cycle();
      redirect_valid = 1'b0;
      run_until_hs(1, 10, ok);
      checks++; if (!ok || last_hs_addr !== 32'h200) begin errors++; $display("[TB] FAIL mis_resume: got addr %h expected 00000200", last_hs_addr); end
   endtask

   task automatic test_resp_err();
      bit ok;
      int h;
      do_reset(1'b1, 1'b1, 1'b0);
      err_addr = 32'h20;
      run_until_pops(9, 40, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL err_timeout: got %0d pops expected 9", pop_pc.size()); end
      checks++; if (pop_pc[8] !== 32'h20 || pop_err[8] !== 1'b1 || pop_inst[8] !== 32'h0000_0013) begin errors++; $display("[TB] FAIL err_entry: got pc %h err %b inst %h expected 00000020 1 00000013", pop_pc[8], pop_err[8], pop_inst[8]); end
      checks++; if (pop_pc[7] !== 32'h1C || pop_err[7] !== 1'b0 || pop_inst[7] !== 32'hA000_001C) begin errors++; $display("[TB] FAIL err_prev: got pc %h err %b inst %h expected 0000001c 0 a000001c", pop_pc[7], pop_err[7], pop_inst[7]); end
      h = hs_count;
      run_cycles(6);
      checks++; if (hs_count !== h) begin errors++; $display("[TB] FAIL err_halt: got %0d requests expected %0d", hs_count, h); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      cycle();
      redirect_valid = 1'b0;
      clear_pops();
      run_until_pops(1, 10, ok);
      checks++; if (!ok || pop_pc[0] !== 32'h40 || pop_err[0] !== 1'b0 || pop_inst[0] !== 32'hA000_0040) begin errors++; $display("[TB] FAIL err_resume: got pc %h err %b inst %h expected 00000040 0 a0000040", pop_pc[0], pop_err[0], pop_inst[0]); end
   endtask

   task automatic test_wrap();
      bit ok;
      do_reset(1'b1, 1'b1, 1'b0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      hs_count = 0;
      run_until_hs(1, 10, ok);
      checks++; if (!ok || last_hs_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_first: got %h expected fffffffc", last_hs_addr); end
      run_until_hs(2, 10, ok);
      checks++; if (!ok || last_hs_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next: got %h expected 00000000", last_hs_addr); end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      do_reset(1'b1, 1'b1, 1'b1);
      run_until_hs(1, 5, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL midwait_setup: got %0d requests expected 1", hs_count); end
      global_rst     = 1'b0;
      auto_mem       = 1'b0;
      mem_resp_valid = 1'b0;
      #3;
      mem_req_ready = 1'b0;
      global_rst    = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL midwait_release: got v %b addr %h inst_valid %b expected 1 00000000 0", mem_req_valid, mem_req_addr, inst_valid); end
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hDEAD_BEEF;
      cycle();
      mem_resp_valid = 1'b0;
      cycle();
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL midwait_late_resp: got inst_valid %b inst %h expected 0", inst_valid, inst); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL midwait_req_stable: got v %b addr %h expected 1 00000000", mem_req_valid, mem_req_addr); end
      p1_v = 1'b0; p2_v = 1'b0;
      lat2 = 1'b0;
      auto_mem = 1'b1;
      mem_req_ready = 1'b1;
      clear_pops();
      run_until_pops(1, 10, ok);
      checks++; if (!ok || pop_pc[0] !== 32'h0 || pop_inst[0] !== 32'h0010_0093) begin errors++; $display("[TB] FAIL midwait_first: got pc %h inst %h expected 00000000 00100093", pop_pc[0], pop_inst[0]); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_back_to_back();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_misaligned();
      test_resp_err();
      test_wrap();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
